// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and default datapath width for the CPU ALU.
package alu_pkg;

  localparam int DATA_W = 32;

  localparam logic [4:0] OP_LOAD  = 5'h00;
  localparam logic [4:0] OP_LOADI = 5'h01;
  localparam logic [4:0] OP_STORE = 5'h02;
  localparam logic [4:0] OP_ADD   = 5'h03;
  localparam logic [4:0] OP_SUB   = 5'h04;
  localparam logic [4:0] OP_AND   = 5'h05;
  localparam logic [4:0] OP_OR    = 5'h06;
  localparam logic [4:0] OP_SHR   = 5'h07;
  localparam logic [4:0] OP_SHRA  = 5'h08;
  localparam logic [4:0] OP_SHL   = 5'h09;
  localparam logic [4:0] OP_ROR   = 5'h0A;
  localparam logic [4:0] OP_ROL   = 5'h0B;
  localparam logic [4:0] OP_ADDI  = 5'h0C;
  localparam logic [4:0] OP_ANDI  = 5'h0D;
  localparam logic [4:0] OP_ORI   = 5'h0E;
  localparam logic [4:0] OP_MUL   = 5'h0F;
  localparam logic [4:0] OP_DIV   = 5'h10;
  localparam logic [4:0] OP_NEG   = 5'h11;
  localparam logic [4:0] OP_NOT   = 5'h12;

endpackage

// File: rtl/alu_divider.sv
// alu_divider: combinational signed divide, quotient truncated toward zero,
// remainder takes the dividend's sign. Divide-by-zero and the single
// overflowing case (most-negative / -1) are resolved explicitly.
module alu_divider #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_dividend,
  input  logic [W-1:0] i_divisor,
  output logic [W-1:0] o_quot,
  output logic [W-1:0] o_rem
);

  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  // Special cases first, then the native signed divide.
  always_comb begin
    o_quot = '0;
    o_rem  = '0;
    if (i_divisor == '0) begin
      o_quot = '1;
      o_rem  = i_dividend;
    end else if (i_dividend == MOST_NEG && i_divisor == '1) begin
      o_quot = MOST_NEG;
      o_rem  = '0;
    end else begin
      o_quot = $signed(i_dividend) / $signed(i_divisor);
      o_rem  = $signed(i_dividend) % $signed(i_divisor);
    end
  end

endmodule

// File: rtl/alu.sv
// alu: CPU datapath ALU. Combinational op mux feeding a 64-bit Z register
// that clears asynchronously while clr is low. IncPC forces b+1.
// Build option: ALU_DIV_EN enables the divider (opcode 10); without it
// opcode 10 returns zero.
module alu #(
  parameter int DATA_W = alu_pkg::DATA_W
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  IncPC,
  input  logic [DATA_W-1:0]     b,
  input  logic [DATA_W-1:0]     y,
  input  logic [4:0]            opcode,
  output logic [2*DATA_W-1:0]   z
);
  import alu_pkg::*;

  localparam int DW = DATA_W;
  localparam int SW = $clog2(DATA_W);

  logic [SW-1:0]          w_sh;
  logic [DW-1:0]          w_sra;
  logic [DW-1:0]          w_ror;
  logic [DW-1:0]          w_rol;
  logic signed [2*DW-1:0] w_mb;
  logic signed [2*DW-1:0] w_my;
  logic signed [2*DW-1:0] w_mul;
  logic [2*DW-1:0]        w_nxt;
  logic [2*DW-1:0]        r_z;

  // Only the low log2(DW) bits of y select a shift distance.
  assign w_sh  = y[SW-1:0];
  assign w_sra = $signed(b) >>> w_sh;
  // Rotates: shift the doubled word and keep the half that wrapped around.
  assign w_ror = DW'({b, b} >> w_sh);
  assign w_rol = DW'(({b, b} << w_sh) >> DW);

  // Full-width signed product; sign-extend before multiplying.
  assign w_mb  = {{DW{b[DW-1]}}, b};
  assign w_my  = {{DW{y[DW-1]}}, y};
  assign w_mul = w_mb * w_my;

`ifdef ALU_DIV_EN
  logic [DW-1:0] w_quot;
  logic [DW-1:0] w_rem;

  alu_divider #(.W(DW)) u_div (
    .i_dividend (b),
    .i_divisor  (y),
    .o_quot     (w_quot),
    .o_rem      (w_rem)
  );
`endif

  // Next Z value: IncPC wins, otherwise decode the opcode; unused codes give 0.
  always_comb begin
    w_nxt = '0;
    if (IncPC) begin
      w_nxt[DW-1:0] = b + {{(DW-1){1'b0}}, 1'b1};
    end else begin
      case (opcode)
        OP_LOAD, OP_LOADI, OP_STORE,
        OP_ADD, OP_ADDI:         w_nxt[DW-1:0] = b + y;
        OP_SUB:                  w_nxt[DW-1:0] = b - y;
        OP_AND, OP_ANDI:         w_nxt[DW-1:0] = b & y;
        OP_OR,  OP_ORI:          w_nxt[DW-1:0] = b | y;
        OP_SHR:                  w_nxt[DW-1:0] = b >> w_sh;
        OP_SHRA:                 w_nxt[DW-1:0] = w_sra;
        OP_SHL:                  w_nxt[DW-1:0] = b << w_sh;
        OP_ROR:                  w_nxt[DW-1:0] = w_ror;
        OP_ROL:                  w_nxt[DW-1:0] = w_rol;
        OP_MUL:                  w_nxt         = w_mul;
`ifdef ALU_DIV_EN
        OP_DIV:                  w_nxt         = {w_rem, w_quot};
`endif
        OP_NEG:                  w_nxt[DW-1:0] = -y;
        OP_NOT:                  w_nxt[DW-1:0] = ~y;
        default:                 w_nxt         = '0;
      endcase
    end
  end

  // Z register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) r_z <= '0;
    else      r_z <= w_nxt;
  end

  assign z = r_z;

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed vector table plus randomized vectors against a
// behavioural model, and hand sequences for the asynchronous clear.
module tb_alu;

`ifdef ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr;
  logic        IncPC;
  logic [31:0] b, y;
  logic [4:0]  opcode;
  logic [63:0] z;

  int vectors = 0;
  int miscompares = 0;

  alu dut (
    .clk    (clk),
    .clr    (clr),
    .IncPC  (IncPC),
    .b      (b),
    .y      (y),
    .opcode (opcode),
    .z      (z)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic        inc;
    logic [31:0] b;
    logic [31:0] y;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl[$];

  // Reference model: arithmetic on 64-bit signed integers.
  function automatic logic [63:0] model(input logic [4:0] op, input logic inc,
                                        input logic [31:0] bv, input logic [31:0] yv);
    longint      sb;
    longint      sy;
    longint      q;
    longint      r;
    int          n;
    logic [63:0] dbl;
    logic [31:0] lo;
    sb  = longint'($signed(bv));
    sy  = longint'($signed(yv));
    n   = int'(yv % 32);
    dbl = {bv, bv};
    lo  = 32'h0;
    if (inc) return {32'h0, bv + 32'd1};
    case (op)
      5'h00, 5'h01, 5'h02, 5'h03, 5'h0C: lo = bv + yv;
      5'h04: lo = bv - yv;
      5'h05, 5'h0D: lo = bv & yv;
      5'h06, 5'h0E: lo = bv | yv;
      5'h07: lo = bv >> n;
      5'h08: lo = 32'(sb >>> n);
      5'h09: lo = bv << n;
      5'h0A: lo = 32'(dbl >> n);
      5'h0B: lo = 32'((dbl << n) >> 32);
      5'h0F: return 64'(sb * sy);
      5'h10: begin
        if (!DIV_EN) return 64'h0;
        if (sy == 0) return {bv, 32'hFFFF_FFFF};
        q = sb / sy;
        r = sb % sy;
        return {32'(r), 32'(q)};
      end
      5'h11: lo = 32'(-sy);
      5'h12: lo = ~yv;
      default: return 64'h0;
    endcase
    return {32'h0, lo};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: z=%h expected %h", name, act, exp);
    end
  endtask

  task automatic add_v(input string name, input logic [4:0] op, input logic inc,
                       input logic [31:0] bv, input logic [31:0] yv, input logic [63:0] exp);
    vec_t v;
    v.name = name; v.op = op; v.inc = inc; v.b = bv; v.y = yv; v.exp = exp;
    tbl.push_back(v);
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic apply(input logic [4:0] op, input logic inc,
                       input logic [31:0] bv, input logic [31:0] yv);
    @(negedge clk);
    opcode = op; IncPC = inc; b = bv; y = yv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    add_v("add",       5'h03, 0, 32'd123,       32'd7,         64'd130);
    add_v("sub",       5'h04, 0, 32'd15,        32'd4,         64'd11);
    add_v("and",       5'h05, 0, 32'h19,        32'h53,        64'h11);
    add_v("or",        5'h06, 0, 32'h11,        32'hF2,        64'hF3);
    add_v("neg",       5'h11, 0, 32'hDEAD_0000, 32'd5,         64'h0000_0000_FFFF_FFFB);
    add_v("not",       5'h12, 0, 32'h1234_5678, 32'hFFFF_FF00, 64'hFF);
    add_v("shr",       5'h07, 0, 32'h1000_0000, 32'd1,         64'h0800_0000);
    add_v("shra",      5'h08, 0, 32'h8000_0000, 32'd4,         64'hF800_0000);
    add_v("shl",       5'h09, 0, 32'd1,         32'd2,         64'd4);
    add_v("ror",       5'h0A, 0, 32'd1,         32'd1,         64'h8000_0000);
    add_v("rol",       5'h0B, 0, 32'h8000_0000, 32'd1,         64'd1);
    add_v("shr_amt0",  5'h07, 0, 32'hDEAD_BEEF, 32'h0000_0020, 64'hDEAD_BEEF);
    add_v("rol_hiy",   5'h0B, 0, 32'h8000_0001, 32'hFFFF_FFE4, 64'h18);
    add_v("load",      5'h00, 0, 32'd5,         32'd6,         64'd11);
    add_v("addi_wrap", 5'h0C, 0, 32'hFFFF_FFFF, 32'd1,         64'h0);
    add_v("andi",      5'h0D, 0, 32'hF0F0_F0F0, 32'hFF00_FF00, 64'hF000_F000);
    add_v("ori",       5'h0E, 0, 32'h0000_000F, 32'h0000_00F0, 64'hFF);
    add_v("mul",       5'h0F, 0, 32'd12,        32'd4,         64'd48);
    add_v("mul_neg",   5'h0F, 0, 32'hFFFF_FFFE, 32'd3,         64'hFFFF_FFFF_FFFF_FFFA);
    add_v("mul_min",   5'h0F, 0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    add_v("div",       5'h10, 0, 32'd12,        32'd27,        DIV_EN ? 64'h0000_000C_0000_0000 : 64'h0);
    add_v("div_neg",   5'h10, 0, 32'hFFFF_FFF9, 32'd2,         DIV_EN ? 64'hFFFF_FFFF_FFFF_FFFD : 64'h0);
    add_v("div_zero",  5'h10, 0, 32'h55,        32'd0,         DIV_EN ? 64'h0000_0055_FFFF_FFFF : 64'h0);
    add_v("div_ovf",   5'h10, 0, 32'h8000_0000, 32'hFFFF_FFFF, DIV_EN ? 64'h0000_0000_8000_0000 : 64'h0);
    add_v("incpc_sub", 5'h04, 1, 32'h0000_00FF, 32'd9,         64'h100);
    add_v("incpc_1f",  5'h1F, 1, 32'h0000_00FF, 32'd9,         64'h100);
    add_v("op_1f",     5'h1F, 0, 32'h0000_00FF, 32'd9,         64'h0);
    add_v("op_13",     5'h13, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0);

    // Reset: clr low clears z regardless of inputs, even across edges.
    clr = 1'b0; IncPC = 1'b0; opcode = 5'h03; b = 32'hFFFF_FFFF; y = 32'h1234_5678;
    #1;
    check("reset_immediate", z, 64'h0);
    @(posedge clk); #1;
    check("reset_held", z, 64'h0);

    // Release clr and take the first result on the next edge.
    @(negedge clk);
    clr = 1'b1; opcode = 5'h03; b = 32'd123; y = 32'd7;
    @(posedge clk); #1;
    check("first_after_clr", z, 64'd130);

    foreach (tbl[i]) begin
      apply(tbl[i].op, tbl[i].inc, tbl[i].b, tbl[i].y);
      check(tbl[i].name, z, tbl[i].exp);
    end

    // Clear asserted mid-cycle: z drops without waiting for an edge.
    apply(5'h0F, 0, 32'hFFFF_FFFE, 32'd3);
    check("pre_midclr", z, 64'hFFFF_FFFF_FFFF_FFFA);
    #2 clr = 1'b0;
    #1 check("midclr_immediate", z, 64'h0);
    @(posedge clk); #1;
    check("midclr_held", z, 64'h0);
    @(negedge clk);
    clr = 1'b1; opcode = 5'h04; IncPC = 1'b0; b = 32'd15; y = 32'd4;
    @(posedge clk); #1;
    check("midclr_recover", z, 64'd11);

    // Randomized vectors, biased toward edge operands.
    for (int i = 0; i < 400; i++) begin
      logic [4:0]  op;
      logic        inc;
      logic [31:0] bv, yv;
      op  = 5'($urandom_range(0, 31));
      inc = ($urandom_range(0, 7) == 0);
      bv  = $urandom;
      yv  = $urandom;
      case ($urandom_range(0, 7))
        0: yv = 32'h0;
        1: yv = 32'($urandom_range(0, 40));
        2: bv = 32'h8000_0000;
        3: yv = 32'hFFFF_FFFF;
        default: ;
      endcase
      apply(op, inc, bv, yv);
      check($sformatf("rand%0d_op%02h", i, op), z, model(op, inc, bv, yv));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
